// File: rtl/clock_pkg.sv
// Shared types and widths for the BCD clock scheduler and its converter.
package clock_pkg;

  localparam int unsigned HoursW        = 5;
  localparam int unsigned MinutesW      = 6;
  localparam int unsigned SecondsW      = 6;
  localparam int unsigned BcdInW        = 7;
  localparam int unsigned BcdW          = 8;
  localparam int unsigned HoursMaxDef   = 23;
  localparam int unsigned SecondsMaxDef = 59;

  typedef enum logic [2:0] {
    StIdle,
    StConvS,
    StConvM,
    StConvH,
    StDone
  } state_e;

endpackage

// File: rtl/binary_to_bcd.sv
// Combinational 7-bit binary to two-digit BCD; values of 100 or more give 8'hFF.
module binary_to_bcd
  import clock_pkg::*;
(
  input  logic [BcdInW-1:0] bin,
  output logic [BcdW-1:0]   bcd
);

  logic [BcdInW-1:0] rem;
  logic [3:0]        tens;

  always_comb begin
    rem  = bin;
    tens = 4'd0;
    bcd  = 8'hFF;
    if (bin < 7'd100) begin
      // Repeated subtraction of ten; at most nine steps for inputs below 100.
      for (int i = 0; i < 9; i++) begin
        if (rem >= 7'd10) begin
          rem  = rem - 7'd10;
          tens = tens + 4'd1;
        end
      end
      bcd = {tens, rem[3:0]};
    end
  end

endmodule

// File: rtl/clock_bcd_scheduler.sv
// Time-multiplexed BCD conversion of an h:m:s snapshot through one shared converter.
// Define CLOCK_BCD_SECONDS_EN to convert seconds; otherwise seconds read as 8'h00.
module clock_bcd_scheduler
  import clock_pkg::*;
#(
  parameter int unsigned SECONDS_MAX = SecondsMaxDef,
  parameter int unsigned HOURS_MAX   = HoursMaxDef
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_refresh,
  input  logic [HoursW-1:0]   i_hours,
  input  logic [MinutesW-1:0] i_minutes,
  input  logic [SecondsW-1:0] i_seconds,
  output logic [BcdW-1:0]     o_hours_bcd,
  output logic [BcdW-1:0]     o_minutes_bcd,
  output logic [BcdW-1:0]     o_seconds_bcd,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_range_err
);

`ifdef CLOCK_BCD_SECONDS_EN
  localparam state_e FirstConv = StConvS;
`else
  localparam state_e FirstConv = StConvM;
`endif

  state_e              state_q, state_d;
  logic                start;
  logic                pending_q, pending_d;
  logic [HoursW-1:0]   snap_h_q;
  logic [MinutesW-1:0] snap_m_q;
  logic [BcdW-1:0]     stg_h_q, stg_m_q;
  logic [BcdW-1:0]     hours_q, minutes_q;
  logic                valid_q, busy_q, range_err_q;
  logic                snap_err;
  logic [BcdInW-1:0]   conv_in;
  logic [BcdW-1:0]     conv_out;

`ifdef CLOCK_BCD_SECONDS_EN
  logic [SecondsW-1:0] snap_s_q;
  logic [BcdW-1:0]     stg_s_q, seconds_q;
`endif

  binary_to_bcd u_conv (
    .bin (conv_in),
    .bcd (conv_out)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start     = 1'b0;
    conv_in   = '0;
    unique case (state_q)
      StIdle: begin
        if (i_refresh) start = 1'b1;
      end
`ifdef CLOCK_BCD_SECONDS_EN
      StConvS: begin
        conv_in = BcdInW'(snap_s_q);
        state_d = StConvM;
        if (i_refresh) pending_d = 1'b1;
      end
`endif
      StConvM: begin
        conv_in = BcdInW'(snap_m_q);
        state_d = StConvH;
        if (i_refresh) pending_d = 1'b1;
      end
      StConvH: begin
        conv_in = BcdInW'(snap_h_q);
        state_d = StDone;
        if (i_refresh) pending_d = 1'b1;
      end
      StDone: begin
        // A request seen during conversion or at this edge chains straight into a new run.
        if (i_refresh || pending_q) begin
          start     = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) state_d = FirstConv;
  end

  always_comb begin
    snap_err = (32'(snap_h_q) > HOURS_MAX) || (32'(snap_m_q) > SECONDS_MAX);
`ifdef CLOCK_BCD_SECONDS_EN
    snap_err = snap_err || (32'(snap_s_q) > SECONDS_MAX);
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      snap_h_q    <= '0;
      snap_m_q    <= '0;
      stg_h_q     <= '0;
      stg_m_q     <= '0;
      hours_q     <= '0;
      minutes_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      valid_q <= (state_q == StDone);
      busy_q  <= (state_q != StIdle);
      if (start) begin
        snap_h_q <= i_hours;
        snap_m_q <= i_minutes;
      end
      if (state_q == StConvM) stg_m_q <= conv_out;
      if (state_q == StConvH) stg_h_q <= conv_out;
      // Publish the whole set on one edge so outputs never mix old and new digits.
      if (state_q == StDone) begin
        hours_q     <= stg_h_q;
        minutes_q   <= stg_m_q;
        range_err_q <= snap_err;
      end
    end
  end

`ifdef CLOCK_BCD_SECONDS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      snap_s_q  <= '0;
      stg_s_q   <= '0;
      seconds_q <= '0;
    end else begin
      if (start)              snap_s_q  <= i_seconds;
      if (state_q == StConvS) stg_s_q   <= conv_out;
      if (state_q == StDone)  seconds_q <= stg_s_q;
    end
  end

  assign o_seconds_bcd = seconds_q;
`else
  logic unused_seconds;
  assign unused_seconds = ^i_seconds;
  assign o_seconds_bcd  = '0;
`endif

  assign o_hours_bcd   = hours_q;
  assign o_minutes_bcd = minutes_q;
  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_range_err   = range_err_q;

endmodule

// File: tb/tb_clock_bcd_scheduler.sv
// Scoreboard bench for clock_bcd_scheduler: rule-level model queues expected publishes.
module tb_clock_bcd_scheduler;

`ifdef CLOCK_BCD_SECONDS_EN
  localparam int Lat   = 4;
  localparam bit SecEn = 1'b1;
`else
  localparam int Lat   = 3;
  localparam bit SecEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_reset, i_refresh;
  logic [4:0] i_hours;
  logic [5:0] i_minutes, i_seconds;
  logic [7:0] o_hours_bcd, o_minutes_bcd, o_seconds_bcd;
  logic       o_valid, o_busy, o_range_err;

  clock_bcd_scheduler dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_refresh     (i_refresh),
    .i_hours       (i_hours),
    .i_minutes     (i_minutes),
    .i_seconds     (i_seconds),
    .o_hours_bcd   (o_hours_bcd),
    .o_minutes_bcd (o_minutes_bcd),
    .o_seconds_bcd (o_seconds_bcd),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_range_err   (o_range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] h, m, s;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   run_s    = -1;
  int   run_f    = -1;
  int   e_edge;
  bit   pend     = 1'b0;
  bit   exp_busy = 1'b0;
  bit   go;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: one run occupies Lat edges; requests during a run collapse and restart at its end.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      exp_q.delete();
      pend     = 1'b0;
      run_s    = -1;
      run_f    = -1;
      exp_busy = 1'b0;
    end else begin
      e_edge   = cyc + 1;
      exp_busy = (e_edge - 1 >= run_s) && (e_edge - 1 < run_f);
      go       = 1'b0;
      if (e_edge >= run_f) begin
        go   = i_refresh || (pend && e_edge == run_f);
        pend = 1'b0;
      end else if (i_refresh) begin
        pend = 1'b1;
      end
      if (go) begin
        run_s = e_edge;
        run_f = e_edge + Lat;
        exp_q.push_back('{due: e_edge + Lat,
                          h:   to_bcd(int'(i_hours)),
                          m:   to_bcd(int'(i_minutes)),
                          s:   SecEn ? to_bcd(int'(i_seconds)) : 8'h00,
                          err: (i_hours > 23) || (i_minutes > 59) ||
                               (SecEn && i_seconds > 59)});
      end
    end
  end

  always @(negedge clk) begin
    if (!i_reset) begin
      chk("busy", 32'(o_busy), 32'(exp_busy));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
        end else begin
          got = exp_q.pop_front();
          chk("latency", 32'(cyc), 32'(got.due));
          chk("hours", 32'(o_hours_bcd), 32'(got.h));
          chk("minutes", 32'(o_minutes_bcd), 32'(got.m));
          chk("seconds", 32'(o_seconds_bcd), 32'(got.s));
          chk("range_err", 32'(o_range_err), 32'(got.err));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid: got valid=0 expected valid=1 at cycle %0d", exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic r, input int h, input int m, input int s);
    i_refresh = r;
    i_hours   = 5'(h);
    i_minutes = 6'(m);
    i_seconds = 6'(s);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) drive(1'b0, 0, 0, 0);
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_hours"}, 32'(o_hours_bcd), 32'h0);
    chk({tag, "_minutes"}, 32'(o_minutes_bcd), 32'h0);
    chk({tag, "_seconds"}, 32'(o_seconds_bcd), 32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_err"}, 32'(o_range_err), 32'h0);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_refresh = 1'b0;
    i_hours   = '0;
    i_minutes = '0;
    i_seconds = '0;
    repeat (3) @(posedge clk);
    #2;
    check_cleared("reset");
    i_reset = 1'b0;
    drive(1'b0, 0, 0, 0);

    // Nominal, boundaries and range error.
    drive(1'b1, 12, 34, 56); wait_idle();
    drive(1'b1, 23, 59, 59); wait_idle();
    drive(1'b1, 0, 0, 0);    wait_idle();
    drive(1'b1, 5, 63, 7);   wait_idle();
    drive(1'b1, 6, 8, 62);   wait_idle();
    drive(1'b1, 24, 10, 10); wait_idle();
    drive(1'b1, 9, 10, 11);  wait_idle();

    // Refresh held for three cycles with inputs changing every cycle.
    drive(1'b1, 1, 2, 3);
    drive(1'b1, 4, 5, 6);
    drive(1'b1, 7, 8, 9);
    for (int i = 0; i < 6; i++) drive(1'b0, 10 + i, 20 + i, 30 + i);
    wait_idle();

    // Reset while in the minutes conversion step.
    drive(1'b1, 21, 43, 54);
    if (SecEn) drive(1'b0, 0, 0, 0);
    i_reset = 1'b1;
    #1;
    check_cleared("midrun");
    repeat (2) @(posedge clk);
    #2;
    i_reset = 1'b0;
    drive(1'b0, 0, 0, 0);
    drive(1'b1, 17, 45, 38); wait_idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        i_reset = 1'b1;
        #1;
        check_cleared("rand_reset");
        @(posedge clk);
        #2;
        i_reset = 1'b0;
      end
      drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end
    wait_idle();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
